// File: rtl/multiword_skip_add_seq_pkg.sv
// Shared definitions for the multi-word carry-skip adder front end.
package multiword_skip_add_seq_pkg;

    // Width of one datapath chunk; matches the carry_skip_16bit adder.
    localparam int CHUNK_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to index WORDS chunks; never less than one bit.
    function automatic int idx_width(input int words);
        int w;
        w = 1;
        while ((1 << w) < words) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/multiword_skip_add_seq_if.sv
// Operand-in / result-out handshake bundle for multiword_skip_add_seq.
interface multiword_skip_add_seq_if #(
    parameter int WORDS = 4
);
    import multiword_skip_add_seq_pkg::*;

    logic                       in_valid;
    logic                       in_ready;
    logic [CHUNK_W*WORDS-1:0]   in_a;
    logic [CHUNK_W*WORDS-1:0]   in_b;
    logic                       in_cin;
    logic                       out_valid;
    logic                       out_ready;
    logic [CHUNK_W*WORDS-1:0]   out_sum;
    logic                       out_cout;
    logic                       busy;

    // Operand source and result consumer side.
    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, busy
    );

    // Adder block side.
    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout, busy
    );

endinterface

// File: rtl/carry_skip_16bit.sv
// 16-bit carry-skip adder: four 4-bit ripple blocks, each bypassed when
// every bit in the block propagates.
module carry_skip_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    logic [4:0] blk_c;

    assign blk_c[0] = cin;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_blk
            logic [3:0] a4;
            logic [3:0] b4;
            logic [3:0] s4;
            logic       rc;
            logic       prop;

            assign a4 = a[gi*4 +: 4];
            assign b4 = b[gi*4 +: 4];
            // Ripple within the block.
            assign {rc, s4} = {1'b0, a4} + {1'b0, b4} + {4'b0000, blk_c[gi]};
            // All-propagate block passes its carry-in straight through.
            assign prop = &(a4 ^ b4);
            assign blk_c[gi+1] = prop ? blk_c[gi] : rc;
            assign sum[gi*4 +: 4] = s4;
        end
    endgenerate

    assign cout = blk_c[4];

endmodule

// File: rtl/multiword_skip_add_seq.sv
// Sequential wide adder: streams WORDS 16-bit chunks (LSW first) through one
// carry_skip_16bit, chaining the carry through a register between chunks.
module multiword_skip_add_seq
    import multiword_skip_add_seq_pkg::*;
#(
    parameter int WORDS = 4,
    parameter int CHUNK = CHUNK_W
) (
    input logic                     clk,
    input logic                     rst_n,
    multiword_skip_add_seq_if.slave bus
);
    localparam int              IDXW     = idx_width(WORDS);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(WORDS - 1);

    state_t                 state_reg;
    state_t                 state_next;
    logic [IDXW-1:0]        idx_reg;
    logic                   carry_reg;
    logic                   cout_reg;
    logic [CHUNK*WORDS-1:0] a_reg;
    logic [CHUNK*WORDS-1:0] b_reg;
    logic [CHUNK-1:0]       a_words       [WORDS];
    logic [CHUNK-1:0]       b_words       [WORDS];
    logic [CHUNK-1:0]       sum_words_reg [WORDS];
    logic [CHUNK-1:0]       add_a;
    logic [CHUNK-1:0]       add_b;
    logic [CHUNK-1:0]       add_sum;
    logic                   add_cout;

    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_chunk
            assign a_words[gi] = a_reg[gi*CHUNK +: CHUNK];
            assign b_words[gi] = b_reg[gi*CHUNK +: CHUNK];
            assign bus.out_sum[gi*CHUNK +: CHUNK] = sum_words_reg[gi];
        end
    endgenerate

    assign add_a        = a_words[idx_reg];
    assign add_b        = b_words[idx_reg];
    assign bus.out_cout = cout_reg;

    carry_skip_16bit u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (carry_reg),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and handshake outputs decoded from the current state.
    always_comb begin
        state_next    = state_reg;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        case (state_reg)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                bus.busy = 1'b1;
                if (idx_reg == IDX_LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                bus.busy      = 1'b1;
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture on accept, then one chunk per cycle into the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            idx_reg   <= '0;
            for (int i = 0; i < WORDS; i++) begin
                sum_words_reg[i] <= '0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg     <= bus.in_a;
                        b_reg     <= bus.in_b;
                        carry_reg <= bus.in_cin;
                        idx_reg   <= '0;
                    end
                end
                RUN: begin
                    sum_words_reg[idx_reg] <= add_sum;
                    carry_reg              <= add_cout;
                    if (idx_reg == IDX_LAST) begin
                        cout_reg <= add_cout;
                        idx_reg  <= '0;
                    end else begin
                        idx_reg <= idx_reg + IDXW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multiword_skip_add_seq.sv
// Self-checking bench for multiword_skip_add_seq (WORDS=4 and WORDS=1 builds).
module tb_multiword_skip_add_seq;
    import multiword_skip_add_seq_pkg::*;

    localparam int WORDS = 4;
    localparam int W     = CHUNK_W * WORDS;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    multiword_skip_add_seq_if #(.WORDS(WORDS)) bus ();
    multiword_skip_add_seq_if #(.WORDS(1))     bus1 ();

    multiword_skip_add_seq #(.WORDS(WORDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    multiword_skip_add_seq #(.WORDS(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    // Reference: plain wide addition.
    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    endfunction

    // Random operand biased toward all-zero / all-one chunks to hit skip paths.
    function automatic logic [W-1:0] rand_operand();
        logic [W-1:0] v;
        v = '0;
        for (int i = 0; i < WORDS; i++) begin
            case ($urandom_range(0, 3))
                0:       v[i*16 +: 16] = 16'h0000;
                1:       v[i*16 +: 16] = 16'hFFFF;
                default: v[i*16 +: 16] = 16'($urandom);
            endcase
        end
        return v;
    endfunction

    // Offer one operand pair, then scramble the inputs and wait for out_valid.
    // lat = edges from the accept edge to out_valid (100 means it never came).
    task automatic send_wait(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                             output int lat);
        int guard;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cin   = cin;
        guard = 0;
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_a     = rand_operand();
        bus.in_b     = rand_operand();
        bus.in_cin   = 1'($urandom);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    // Consume the pending result over one cycle.
    task automatic release_out();
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.out_sum !== '0) begin errors++; $display("FAIL reset_out_sum: got %h want 0", bus.out_sum); end
        checks++; if (bus.out_cout !== 1'b0) begin errors++; $display("FAIL reset_out_cout: got %b want 0", bus.out_cout); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle: in_ready %b busy %b want 1 0", bus.in_ready, bus.busy); end
    endtask

    task automatic test_directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic [W-1:0] exp_sum, input logic exp_cout);
        int lat;
        send_wait(a, b, cin, lat);
        checks++; if (lat != WORDS) begin errors++; $display("FAIL %s_latency: got %0d want %0d", name, lat, WORDS); end
        checks++; if (bus.out_sum !== exp_sum) begin errors++; $display("FAIL %s_sum: got %h want %h", name, bus.out_sum, exp_sum); end
        checks++; if (bus.out_cout !== exp_cout) begin errors++; $display("FAIL %s_cout: got %b want %b", name, bus.out_cout, exp_cout); end
        release_out();
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL %s_release: out_valid %b in_ready %b want 0 1", name, bus.out_valid, bus.in_ready); end
        $display("txn %s: a=%h b=%h cin=%b sum=%h cout=%b lat=%0d", name, a, b, cin, bus.out_sum, bus.out_cout, lat);
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        logic [W-1:0] exp_sum;
        exp_sum = 64'h2222_2222_2222_2211;
        send_wait(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, lat);
        checks++; if (lat != WORDS) begin errors++; $display("FAIL bp_latency: got %0d want %0d", lat, WORDS); end
        // A competing offer during the stall must not be taken.
        bus.in_valid = 1'b1;
        bus.in_a     = '1;
        bus.in_b     = '1;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.out_valid !== 1'b1 || bus.out_sum !== exp_sum || bus.out_cout !== 1'b0 ||
                bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
                bad++;
            end
            @(negedge clk);
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold: %0d unstable cycles, sum %h want %h cout %b want 0", bad, bus.out_sum, exp_sum, bus.out_cout); end
        bus.in_valid = 1'b0;
        release_out();
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release: in_ready %b out_valid %b want 1 0", bus.in_ready, bus.out_valid); end
        $display("txn backpressure: sum=%h cout=%b held 10 cycles", exp_sum, 1'b0);
    endtask

    task automatic test_reset_mid_run();
        int seen;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a     = rand_operand() | 64'h1;
        bus.in_b     = rand_operand();
        bus.in_cin   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL midrun_ctrl: in_ready %b busy %b want 1 0", bus.in_ready, bus.busy); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrun_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.out_sum !== '0 || bus.out_cout !== 1'b0) begin errors++; $display("FAIL midrun_result: sum %h cout %b want 0 0", bus.out_sum, bus.out_cout); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        checks++; if (seen != 0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL midrun_after: out_valid cycles %0d want 0, in_ready %b want 1", seen, bus.in_ready); end
        $display("txn reset_mid_run: discarded, idle afterwards");
    endtask

    task automatic test_back_to_back();
        int n;
        int acc[$];
        logic [W:0] res[$];
        bit loaded;
        bus.out_ready = 1'b1;
        loaded = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a     = '1;
        bus.in_b     = '1;
        bus.in_cin   = 1'b1;
        n = 0;
        while (n < 60 && res.size() < 2) begin
            if (bus.out_valid) res.push_back({bus.out_cout, bus.out_sum});
            if (bus.in_valid && bus.in_ready) acc.push_back(n);
            @(negedge clk);
            n++;
            if (acc.size() == 1 && !loaded) begin
                bus.in_a   = '0;
                bus.in_b   = '0;
                bus.in_cin = 1'b0;
                loaded     = 1'b1;
            end
            if (acc.size() == 2) bus.in_valid = 1'b0;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        checks++;
        if (acc.size() != 2) begin
            errors++; $display("FAIL b2b_accepts: got %0d want 2", acc.size());
        end else if (acc[1] - acc[0] != WORDS + 2) begin
            errors++; $display("FAIL b2b_spacing: got %0d want %0d", acc[1] - acc[0], WORDS + 2);
        end
        checks++;
        if (res.size() != 2) begin
            errors++; $display("FAIL b2b_results: got %0d want 2", res.size());
        end else begin
            if (res[0] !== {1'b1, {W{1'b1}}}) begin errors++; $display("FAIL b2b_first: got %h want %h", res[0], {1'b1, {W{1'b1}}}); end
            checks++;
            if (res[1] !== '0) begin errors++; $display("FAIL b2b_second: got %h want 0", res[1]); end
            $display("txn back_to_back: r0=%h r1=%h", res[0], res[1]);
        end
    endtask

    task automatic test_random();
        int lat;
        int bad;
        int stall;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic cin;
        logic [W:0] exp;
        for (int t = 0; t < 20; t++) begin
            a     = rand_operand();
            b     = rand_operand();
            cin   = 1'($urandom);
            exp   = ref_add(a, b, cin);
            stall = $urandom_range(0, 3);
            send_wait(a, b, cin, lat);
            checks++; if (lat != WORDS) begin errors++; $display("FAIL rand%0d_latency: got %0d want %0d", t, lat, WORDS); end
            checks++; if ({bus.out_cout, bus.out_sum} !== exp) begin errors++; $display("FAIL rand%0d_result: got %h want %h", t, {bus.out_cout, bus.out_sum}, exp); end
            bad = 0;
            for (int c = 0; c < stall; c++) begin
                @(negedge clk);
                if (bus.out_valid !== 1'b1 || {bus.out_cout, bus.out_sum} !== exp) bad++;
            end
            checks++; if (bad != 0) begin errors++; $display("FAIL rand%0d_hold: %0d unstable cycles", t, bad); end
            release_out();
            $display("txn rand%0d: a=%h b=%h cin=%b sum=%h cout=%b stall=%0d", t, a, b, cin, exp[W-1:0], exp[W], stall);
        end
    endtask

    task automatic test_words1();
        int lat;
        @(negedge clk);
        bus1.in_valid = 1'b1;
        bus1.in_a     = 16'h8000;
        bus1.in_b     = 16'h8000;
        bus1.in_cin   = 1'b0;
        checks++; if (bus1.in_ready !== 1'b1) begin errors++; $display("FAIL w1_ready: got %b want 1", bus1.in_ready); end
        @(posedge clk);
        @(negedge clk);
        bus1.in_valid = 1'b0;
        bus1.in_a     = 16'h1234;
        lat = 0;
        while (!bus1.out_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        checks++; if (lat != 1) begin errors++; $display("FAIL w1_latency: got %0d want 1", lat); end
        checks++; if (bus1.out_sum !== 16'h0000 || bus1.out_cout !== 1'b1) begin errors++; $display("FAIL w1_result: sum %h cout %b want 0000 1", bus1.out_sum, bus1.out_cout); end
        bus1.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus1.out_ready = 1'b0;
        checks++; if (bus1.in_ready !== 1'b1 || bus1.out_valid !== 1'b0) begin errors++; $display("FAIL w1_release: in_ready %b out_valid %b want 1 0", bus1.in_ready, bus1.out_valid); end
        $display("txn words1: a=8000 b=8000 cin=0 sum=%h cout=%b lat=%0d", bus1.out_sum, bus1.out_cout, lat);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_a       = '0;
        bus.in_b       = '0;
        bus.in_cin     = 1'b0;
        bus.out_ready  = 1'b0;
        bus1.in_valid  = 1'b0;
        bus1.in_a      = '0;
        bus1.in_b      = '0;
        bus1.in_cin    = 1'b0;
        bus1.out_ready = 1'b0;

        test_reset();
        test_directed("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0,
                      64'h0000_0000_0000_0000, 1'b1);
        // 0x0000_FFFF_0000_FFFF + 1: only the lowest chunk overflows.
        test_directed("skip_cin", 64'h0000_FFFF_0000_FFFF, 64'h0000_0000_0000_0000, 1'b1,
                      64'h0000_FFFF_0001_0000, 1'b0);
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        test_words1();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
